// File: rtl/pifregbank.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | pifregbank : PIF control register bank (ID/ptr, scratch, misc, status)   |
// | Rev 1.0    : initial release                                             |
// +--------------------------------------------------------------------------+
module pifregbank #(
    parameter int                 DATA_W      = 8,
    parameter int                 ADDR_W      = 4,
    parameter int                 SUBA_W      = 4,
    parameter int                 BASE_ADDR   = 0,
    parameter int                 NUM_SCRATCH = 4,
    parameter logic [DATA_W-1:0]  SCRATCH_RST = 'h15,
    parameter int                 MISC_W      = 2,
    parameter logic [MISC_W-1:0]  MISC_RST    = MISC_W'(2'b01),
    parameter int                 EV_W        = 4,
    parameter logic [7:0]         ID_BYTE     = 8'h49
) (
    input  logic              xclk,
    input  logic              sys_rst,
    input  logic              XI_PWr,
    input  logic [ADDR_W-1:0] XI_PRWA,
    input  logic              XI_PRdFinished,
    input  logic [SUBA_W-1:0] XI_PRdSubA,
    input  logic [DATA_W-1:0] XI_PD,
    input  logic [EV_W-1:0]   ev_in,
    output logic [DATA_W-1:0] XO,
    output logic [MISC_W-1:0] MiscReg
);

    localparam int         PTR_W  = $clog2(NUM_SCRATCH);
    localparam logic [1:0] c_ID   = 2'd0;
    localparam logic [1:0] c_SCR  = 2'd1;
    localparam logic [1:0] c_MISC = 2'd2;
    localparam logic [1:0] c_STAT = 2'd3;

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [DATA_W-1:0] scratch_q [NUM_SCRATCH];
    logic [MISC_W-1:0] misc_q, misc_d, miscreg_q;
    logic [EV_W-1:0]   status_q, status_d;

    logic              s1_own_q;
    logic [1:0]        s1_sel_q;
    logic [SUBA_W-1:0] s1_sub_q;
    logic [DATA_W-1:0] s2_data_q, s2_data_d;
    logic [DATA_W-1:0] xo_q;

    logic       w_own;
    logic [1:0] w_sel;
    logic       w_wr_id, w_wr_scr, w_wr_misc, w_wr_stat, w_fin_scr, w_fin_stat;
    logic [EV_W-1:0] w_rclr, w_wclr;

    assign w_own = (32'(XI_PRWA) >= 32'(BASE_ADDR)) &&
                   (32'(XI_PRWA) <= 32'(BASE_ADDR) + 32'd3);
    assign w_sel = 2'(XI_PRWA - ADDR_W'(BASE_ADDR));

    assign w_wr_id    = XI_PWr & w_own & (w_sel == c_ID);
    assign w_wr_scr   = XI_PWr & w_own & (w_sel == c_SCR);
    assign w_wr_misc  = XI_PWr & w_own & (w_sel == c_MISC);
    assign w_wr_stat  = XI_PWr & w_own & (w_sel == c_STAT);
    assign w_fin_scr  = XI_PRdFinished & w_own & (w_sel == c_SCR);
    assign w_fin_stat = XI_PRdFinished & w_own & (w_sel == c_STAT);

    // Read-clear uses what is on XO, so only bits the host actually saw are dropped.
    assign w_rclr = w_fin_stat ? xo_q[EV_W-1:0] : '0;
    assign w_wclr = w_wr_stat  ? XI_PD[EV_W-1:0] : '0;

    always_comb begin
        ptr_d    = ptr_q;
        misc_d   = misc_q;
        if (w_wr_id)
            ptr_d = XI_PD[PTR_W-1:0];
        else if (w_wr_scr || w_fin_scr)
            ptr_d = ptr_q + PTR_W'(1);
        if (w_wr_misc)
            misc_d = XI_PD[MISC_W-1:0];
        status_d = (status_q & ~w_rclr & ~w_wclr) | ev_in;
    end

    always_ff @(posedge xclk or negedge sys_rst) begin
        if (!sys_rst) begin
            ptr_q     <= '0;
            misc_q    <= MISC_RST;
            miscreg_q <= MISC_RST;
            status_q  <= '0;
            for (int i = 0; i < NUM_SCRATCH; i++)
                scratch_q[i] <= SCRATCH_RST;
        end else begin
            ptr_q     <= ptr_d;
            misc_q    <= misc_d;
            miscreg_q <= misc_q;
            status_q  <= status_d;
            if (w_wr_scr)
                scratch_q[ptr_q] <= XI_PD;
        end
    end

    always_comb begin
        s2_data_d = '0;
        if (s1_own_q) begin
            case (s1_sel_q)
                c_ID: begin
                    if (s1_sub_q == SUBA_W'(0))
                        s2_data_d = DATA_W'(ID_BYTE);
                    else if (s1_sub_q == SUBA_W'(1))
                        s2_data_d = DATA_W'(NUM_SCRATCH);
                    else if (s1_sub_q == SUBA_W'(2))
                        s2_data_d = DATA_W'(ptr_q);
                    else if (s1_sub_q == SUBA_W'(3))
                        s2_data_d = DATA_W'({4'h5, 4'(misc_q)});
                    else
                        s2_data_d = DATA_W'({4'h6, 4'(s1_sub_q)});
                end
                c_SCR:   s2_data_d = scratch_q[ptr_q];
                c_MISC:  s2_data_d = DATA_W'(misc_q);
                default: s2_data_d = DATA_W'(status_q);
            endcase
        end
    end

    // Decode -> select -> output; an unowned address yields zero for OR-combining.
    always_ff @(posedge xclk or negedge sys_rst) begin
        if (!sys_rst) begin
            s1_own_q  <= 1'b0;
            s1_sel_q  <= '0;
            s1_sub_q  <= '0;
            s2_data_q <= '0;
            xo_q      <= '0;
        end else begin
            s1_own_q  <= w_own;
            s1_sel_q  <= w_sel;
            s1_sub_q  <= XI_PRdSubA;
            s2_data_q <= s2_data_d;
            xo_q      <= s2_data_q;
        end
    end

    assign XO      = xo_q;
    assign MiscReg = miscreg_q;

endmodule
`default_nettype wire

// File: tb/tb_pifregbank.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_pifregbank : scoreboard bench for pifregbank                          |
// | Rev 1.0       : initial release                                          |
// +--------------------------------------------------------------------------+
module tb_pifregbank;

    localparam int DW = 8, AW = 4, SW = 4, BASE = 4, NS = 4, MW = 2, EW = 4;
    localparam logic [7:0]    ID_V   = 8'hC3;
    localparam logic [MW-1:0] MISC_R = 2'b01;
    localparam logic [AW-1:0] A_ID   = AW'(BASE);
    localparam logic [AW-1:0] A_SCR  = AW'(BASE + 1);
    localparam logic [AW-1:0] A_MISC = AW'(BASE + 2);
    localparam logic [AW-1:0] A_STAT = AW'(BASE + 3);
    localparam logic [AW-1:0] A_UNHI = AW'(BASE + 4);
    localparam logic [AW-1:0] A_UNLO = AW'(BASE - 1);

    logic          xclk = 1'b0;
    logic          sys_rst;
    logic          XI_PWr, XI_PRdFinished;
    logic [AW-1:0] XI_PRWA;
    logic [SW-1:0] XI_PRdSubA;
    logic [DW-1:0] XI_PD;
    logic [EW-1:0] ev_in;
    logic [DW-1:0] XO;
    logic [MW-1:0] MiscReg;

    pifregbank #(
        .DATA_W(DW), .ADDR_W(AW), .SUBA_W(SW), .BASE_ADDR(BASE),
        .NUM_SCRATCH(NS), .SCRATCH_RST(8'h15), .MISC_W(MW),
        .MISC_RST(MISC_R), .EV_W(EW), .ID_BYTE(ID_V)
    ) dut (
        .xclk(xclk), .sys_rst(sys_rst), .XI_PWr(XI_PWr), .XI_PRWA(XI_PRWA),
        .XI_PRdFinished(XI_PRdFinished), .XI_PRdSubA(XI_PRdSubA),
        .XI_PD(XI_PD), .ev_in(ev_in), .XO(XO), .MiscReg(MiscReg)
    );

    always #5 xclk = ~xclk;

    // kind: 0 = XO now, 1 = MiscReg now, 2 = read queue drained
    typedef struct { string name; int kind; logic [DW-1:0] exp; } chk_t;
    chk_t rdq[$];
    chk_t nowq[$];
    chk_t mon_e;
    logic [31:0] mon_act;
    int errors = 0;
    int checks = 0;
    logic       rd_issue = 1'b0;
    logic [2:0] pipe = '0;

    always @(posedge xclk) pipe <= {pipe[1:0], rd_issue};

    always @(negedge xclk) begin
        if (pipe[2]) begin
            checks++;
            if (rdq.size() == 0) begin
                errors++;
                $display("FAIL read_unexpected: XO=%0h with no expected entry", XO);
            end else begin
                mon_e = rdq.pop_front();
                if (XO !== mon_e.exp) begin
                    errors++;
                    $display("FAIL %s: XO got %0h, expected %0h", mon_e.name, XO, mon_e.exp);
                end
            end
        end
        while (nowq.size() > 0) begin
            mon_e = nowq.pop_front();
            if (mon_e.kind == 0)      mon_act = 32'(XO);
            else if (mon_e.kind == 1) mon_act = 32'(MiscReg);
            else                      mon_act = 32'(rdq.size());
            checks++;
            if (mon_act !== 32'(mon_e.exp)) begin
                errors++;
                $display("FAIL %s: got %0h, expected %0h", mon_e.name, mon_act, mon_e.exp);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge xclk);
        #1;
    endtask

    task automatic expect_now(input string n, input int k, input logic [DW-1:0] e);
        nowq.push_back('{n, k, e});
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        XI_PRWA = a; XI_PD = d; XI_PWr = 1'b1;
        tick(1);
        XI_PWr = 1'b0;
    endtask

    // Returns on the cycle XO is due; the monitor compares at the next falling edge.
    task automatic rd(input logic [AW-1:0] a, input logic [SW-1:0] s,
                      input logic [DW-1:0] e, input string n);
        XI_PRWA = a; XI_PRdSubA = s; rd_issue = 1'b1;
        rdq.push_back('{n, 0, e});
        tick(1);
        rd_issue = 1'b0;
        tick(2);
    endtask

    task automatic fin();
        XI_PRdFinished = 1'b1;
        tick(1);
        XI_PRdFinished = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst = 1'b0; XI_PWr = 1'b0; XI_PRdFinished = 1'b0;
        XI_PRWA = '0; XI_PRdSubA = '0; XI_PD = '0; ev_in = '0;
        tick(3);
        sys_rst = 1'b1;
        expect_now("rst_xo", 0, 8'h00);
        expect_now("rst_miscreg", 1, DW'(MISC_R));
        tick(1);

        rd(A_ID, 4'd0, ID_V,  "id_sub0");
        rd(A_ID, 4'd1, 8'h04, "id_sub1_nscr");
        rd(A_ID, 4'd7, 8'h67, "id_sub7");
        rd(A_ID, 4'd2, 8'h00, "id_ptr_rst");
        rd(A_ID, 4'd3, 8'h51, "id_sub3_misc");

        wr(A_ID, 8'h02);
        wr(A_SCR, 8'hA1);
        wr(A_SCR, 8'hA2);
        wr(A_SCR, 8'hA3);
        rd(A_ID, 4'd2, 8'h01, "ptr_after_wrap");

        wr(A_ID, 8'h00);
        rd(A_SCR, 4'd0, 8'hA3, "burst0"); fin();
        rd(A_SCR, 4'd0, 8'h15, "burst1"); fin();
        rd(A_SCR, 4'd0, 8'hA1, "burst2"); fin();
        rd(A_SCR, 4'd0, 8'hA2, "burst3"); fin();
        rd(A_ID, 4'd2, 8'h00, "ptr_burst_wrap");

        ev_in = 4'b0101;
        tick(1);
        ev_in = '0;
        rd(A_STAT, 4'd0, 8'h05, "status_set");
        XI_PRdFinished = 1'b1; ev_in = 4'b0001;
        tick(1);
        XI_PRdFinished = 1'b0; ev_in = '0;
        rd(A_STAT, 4'd0, 8'h01, "status_rclr_setprio");
        wr(A_STAT, 8'h01);
        rd(A_STAT, 4'd0, 8'h00, "status_w1c");

        wr(A_MISC, 8'h02);
        expect_now("miscreg_lag1", 1, DW'(MISC_R));
        tick(1);
        expect_now("miscreg_lag2", 1, 8'h02);
        rd(A_MISC, 4'd0, 8'h02, "misc_rd");
        rd(A_ID, 4'd3, 8'h52, "id_sub3_misc2");

        rd(A_UNHI, 4'd0, 8'h00, "unowned_hi");
        rd(A_UNLO, 4'd0, 8'h00, "unowned_lo");

        rd(A_MISC, 4'd0, 8'h02, "misc_pre_rst");
        tick(1);
        XI_PRWA = A_SCR;
        tick(1);
        sys_rst = 1'b0;
        expect_now("midrd_rst_xo", 0, 8'h00);
        expect_now("midrd_rst_miscreg", 1, DW'(MISC_R));
        tick(2);
        sys_rst = 1'b1;
        tick(2);
        expect_now("rel_plus2_xo", 0, 8'h00);
        tick(1);
        expect_now("rel_plus3_scratch", 0, 8'h15);
        tick(1);
        rd(A_MISC, 4'd0, DW'(MISC_R), "misc_after_rst");

        tick(2);
        expect_now("read_queue_drained", 2, 8'h00);
        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
